// File: rtl/hydra_pkg.sv
// Shared types and sizes for the per-port write-side packer.
package hydra_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned LINE_W     = DATA_W * LINE_WORDS;
    localparam int unsigned CODE_W     = 8;
    localparam int unsigned CNT_W      = 4;

    // One queue entry: a committed line plus its sideband.
    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic [CODE_W-1:0] code;
        logic [CNT_W-1:0]  cnt;
        logic              first;
        logic              last;
    } line_t;

endpackage

// File: rtl/ecc_encoder.sv
// Line ECC encoder: code bit i is the parity of every line bit j with j mod 8 == i.
module ecc_encoder
    import hydra_pkg::*;
(
    input  logic [LINE_W-1:0] data,
    output logic [CODE_W-1:0] code
);

    // Fold the line into CODE_W interleaved parity bits.
    always_comb begin
        code = '0;
        for (int unsigned j = 0; j < LINE_W; j++) begin
            code[j % CODE_W] = code[j % CODE_W] ^ data[j];
        end
    end

endmodule

// File: rtl/port_packer.sv
// Per-port packer: assembles 16-bit words into 128-bit lines and queues
// them in a 2-entry FIFO toward the SRAM write arbiter.
// Optional feature macro: PACKER_ECC_EN (attach ECC code to each line).
module port_packer
    import hydra_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [DATA_W-1:0] in_data,
    output logic              line_vld,
    input  logic              line_rdy,
    output logic [LINE_W-1:0] line_data,
    output logic [CODE_W-1:0] line_code,
    output logic [CNT_W-1:0]  line_cnt,
    output logic              line_first,
    output logic              line_last,
    output logic              full,
    output logic              almost_full,
    output logic              err_ovf,
    output logic              err_sop
);

    logic [LINE_W-1:0] asm_data_q, asm_data_d;
    logic [CNT_W-1:0]  acnt_q, acnt_d;
    logic              first_q, first_d;
    line_t             mem_q [2];
    line_t             mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_sop_q, err_sop_d;

    logic              accept;
    logic              commit;
    logic              pop;
    logic [CNT_W-1:0]  slot;
    logic [LINE_W-1:0] merged;
    logic              merged_first;
    logic [CODE_W-1:0] push_code;
    line_t             push_line;
    line_t             head;

`ifdef PACKER_ECC_EN
    ecc_encoder u_ecc (
        .data (merged),
        .code (push_code)
    );
`else
    // Code field of every entry stays constant zero.
    assign push_code = '0;
`endif

    // Assembly: merge the incoming word, decide commit, track sticky errors.
    always_comb begin
        accept       = in_vld && !full_q;
        // A sop word restarts assembly at slot 0 on a cleared line.
        slot         = in_sop ? '0 : acnt_q;
        merged       = in_sop ? '0 : asm_data_q;
        merged[DATA_W*slot +: DATA_W] = in_data;
        merged_first = in_sop || first_q;
        commit       = accept && ((slot == CNT_W'(LINE_WORDS-1)) || in_eop);

        push_line.data  = merged;
        push_line.code  = push_code;
        push_line.cnt   = slot + 4'd1;
        push_line.first = merged_first;
        push_line.last  = in_eop;

        asm_data_d = asm_data_q;
        acnt_d     = acnt_q;
        first_d    = first_q;
        if (commit) begin
            asm_data_d = '0;
            acnt_d     = '0;
            first_d    = 1'b0;
        end else if (accept) begin
            asm_data_d = merged;
            acnt_d     = slot + 4'd1;
            first_d    = merged_first;
        end

        err_ovf_d = err_ovf_q || (in_vld && full_q);
        err_sop_d = err_sop_q || (accept && in_sop && (acnt_q != '0));
    end

    // Queue: push on commit, pop on accepted head, registered flags.
    always_comb begin
        pop      = (count_q != 2'd0) && line_rdy;
        mem_d    = mem_q;
        if (commit) begin
            mem_d[wr_ptr_q] = push_line;
        end
        wr_ptr_d = wr_ptr_q ^ commit;
        rd_ptr_d = rd_ptr_q ^ pop;
        unique case ({commit, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == 2'd2);
        afull_d = (count_d != 2'd0) && (acnt_d >= 4'd6);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_data_q <= '0;
            acnt_q     <= '0;
            first_q    <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_sop_q  <= 1'b0;
        end else begin
            asm_data_q <= asm_data_d;
            acnt_q     <= acnt_d;
            first_q    <= first_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            err_ovf_q  <= err_ovf_d;
            err_sop_q  <= err_sop_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign line_vld    = (count_q != 2'd0);
    assign line_data   = head.data;
    assign line_code   = head.code;
    assign line_cnt    = head.cnt;
    assign line_first  = head.first;
    assign line_last   = head.last;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign err_ovf     = err_ovf_q;
    assign err_sop     = err_sop_q;

endmodule
